// File: rtl/axis_data_checker_cntr.sv
// AXI-Stream sink that checks an incrementing counter stream.
// It applies a rotating backpressure pattern on tready and counts data, tkeep
// and tlast errors as well as accepted packets.
module axis_data_checker_cntr #(
  parameter int                           AXIS_DATA_WIDTH = 32,
  parameter logic [AXIS_DATA_WIDTH/8-1:0] AXIS_TKEEP      = '1,
  parameter int                           PACKET_LEN      = 16,
  parameter logic [AXIS_DATA_WIDTH-1:0]   START_VALUE     = '0,
  parameter logic [7:0]                   READY_PATTERN   = 8'hFF,
  parameter bit                           STOP_ON_ERROR   = 1'b0,
  parameter int                           CNT_WIDTH       = 16
) (
  input  logic                         clk_i,
  input  logic                         s_rst_i,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
  input  logic                         s_axis_tvalid_i,
  input  logic                         s_axis_tlast_i,
  output logic                         s_axis_tready_o,
  output logic [CNT_WIDTH-1:0]         err_cnt_o,
  output logic [CNT_WIDTH-1:0]         pkt_cnt_o,
  output logic                         error_o,
  output logic                         halted_o
);

  localparam int IDX_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [7:0]                   pattern;
  logic [AXIS_DATA_WIDTH-1:0]   exp_data;
  logic [IDX_W-1:0]             beat_idx;
  logic [CNT_WIDTH-1:0]         err_cnt;
  logic [CNT_WIDTH-1:0]         pkt_cnt;
  logic                         error_flag;
  logic                         accept;
  logic                         data_err;
  logic                         keep_err;
  logic                         last_err;
  logic                         beat_err;

  // tready is decoded from registered state only, so it never depends on tvalid.
  // A clear in the same cycle as a handshake drops that beat from every check.
  assign s_axis_tready_o = (state == RUN) & pattern[0];
  assign accept          = s_axis_tvalid_i & s_axis_tready_o & ~clear_i;
  assign data_err        = (s_axis_tdata_i != exp_data);
  assign keep_err        = (s_axis_tkeep_i != AXIS_TKEEP);
  assign last_err        = (s_axis_tlast_i != (beat_idx == LAST_IDX));
  assign beat_err        = accept & (data_err | keep_err | last_err);

  assign err_cnt_o = err_cnt;
  assign pkt_cnt_o = pkt_cnt;
  assign error_o   = error_flag;
  assign halted_o  = (state == HALT);

  // State register.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave RUN only at a packet boundary. HALT is left only by reset.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable_i) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (STOP_ON_ERROR && beat_err) begin
          state_next = HALT;
        end else if (!enable_i && (beat_idx == '0)) begin
          state_next = IDLE;
        end
      end
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Backpressure pattern rotates right every RUN cycle and holds otherwise.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      pattern <= READY_PATTERN;
    end else if (state == RUN) begin
      pattern <= {pattern[0], pattern[7:1]};
    end
  end

  // Expectation tracking and counters. Expected data and beat position resync
  // to what was received, so a single corruption is not reported endlessly.
  always_ff @(posedge clk_i) begin
    if (s_rst_i || clear_i) begin
      exp_data   <= START_VALUE;
      beat_idx   <= '0;
      err_cnt    <= '0;
      pkt_cnt    <= '0;
      error_flag <= 1'b0;
    end else if (accept) begin
      exp_data <= s_axis_tdata_i + AXIS_DATA_WIDTH'(1);
      if (s_axis_tlast_i || (beat_idx == LAST_IDX)) begin
        beat_idx <= '0;
      end else begin
        beat_idx <= beat_idx + IDX_W'(1);
      end
      if (s_axis_tlast_i) begin
        pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      end
      if (beat_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
      if (beat_err) begin
        error_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_data_checker_cntr.sv
// Testbench for axis_data_checker_cntr.
// Four differently parameterised instances share one stimulus bus, and sel
// routes the handshake to one of them. The driver pushes the expected
// post-beat outputs into a queue. A monitor pops one entry for every
// accepted beat and compares it with the outputs after that beat.
module tb_axis_data_checker_cntr;

  typedef struct {
    logic [15:0] err;
    logic [15:0] pkt;
    logic        error;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear;
  logic        tvalid;
  logic        tlast;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic [1:0]  sel;

  logic [3:0]  tready_v;
  logic [3:0]  error_v;
  logic [3:0]  halt_v;
  logic [15:0] err_v [4];
  logic [15:0] pkt_v [4];

  logic        tready_m;
  logic        error_m;
  logic        halt_m;
  logic [15:0] err_m;
  logic [15:0] pkt_m;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        pending = 1'b0;
  logic        rec [64];
  int          rec_n = 0;
  bit          rec_on = 1'b0;

  // Free-running clock.
  always #5 clk = ~clk;

  assign tready_m = tready_v[sel];
  assign error_m  = error_v[sel];
  assign halt_m   = halt_v[sel];
  assign err_m    = err_v[sel];
  assign pkt_m    = pkt_v[sel];

  axis_data_checker_cntr u_dut0 (
    .clk_i(clk), .s_rst_i(rst), .enable_i(enable && sel == 2'd0), .clear_i(clear),
    .s_axis_tdata_i(tdata), .s_axis_tkeep_i(tkeep),
    .s_axis_tvalid_i(tvalid && sel == 2'd0), .s_axis_tlast_i(tlast),
    .s_axis_tready_o(tready_v[0]), .err_cnt_o(err_v[0]), .pkt_cnt_o(pkt_v[0]),
    .error_o(error_v[0]), .halted_o(halt_v[0]));

  axis_data_checker_cntr #(.READY_PATTERN(8'b0101_0101)) u_dut1 (
    .clk_i(clk), .s_rst_i(rst), .enable_i(enable && sel == 2'd1), .clear_i(clear),
    .s_axis_tdata_i(tdata), .s_axis_tkeep_i(tkeep),
    .s_axis_tvalid_i(tvalid && sel == 2'd1), .s_axis_tlast_i(tlast),
    .s_axis_tready_o(tready_v[1]), .err_cnt_o(err_v[1]), .pkt_cnt_o(pkt_v[1]),
    .error_o(error_v[1]), .halted_o(halt_v[1]));

  axis_data_checker_cntr #(.START_VALUE(32'hFFFF_FFFE)) u_dut2 (
    .clk_i(clk), .s_rst_i(rst), .enable_i(enable && sel == 2'd2), .clear_i(clear),
    .s_axis_tdata_i(tdata), .s_axis_tkeep_i(tkeep),
    .s_axis_tvalid_i(tvalid && sel == 2'd2), .s_axis_tlast_i(tlast),
    .s_axis_tready_o(tready_v[2]), .err_cnt_o(err_v[2]), .pkt_cnt_o(pkt_v[2]),
    .error_o(error_v[2]), .halted_o(halt_v[2]));

  axis_data_checker_cntr #(.STOP_ON_ERROR(1'b1)) u_dut3 (
    .clk_i(clk), .s_rst_i(rst), .enable_i(enable && sel == 2'd3), .clear_i(clear),
    .s_axis_tdata_i(tdata), .s_axis_tkeep_i(tkeep),
    .s_axis_tvalid_i(tvalid && sel == 2'd3), .s_axis_tlast_i(tlast),
    .s_axis_tready_o(tready_v[3]), .err_cnt_o(err_v[3]), .pkt_cnt_o(pkt_v[3]),
    .error_o(error_v[3]), .halted_o(halt_v[3]));

  // Compare one observed value against its expectation and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance n clock cycles, leaving time just after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat, hold it until the selected DUT accepts it, and queue the
  // outputs expected after that beat.
  task automatic applyStimulus(input logic [31:0] d, input logic [3:0] k, input logic l,
                               input int e_err, input int e_pkt,
                               input logic e_error, input logic e_halt);
    exp_t e;
    bit   acc;
    int   n;
    e.err    = 16'(e_err);
    e.pkt    = 16'(e_pkt);
    e.error  = e_error;
    e.halted = e_halt;
    sb.push_back(e);
    tdata  = d;
    tkeep  = k;
    tlast  = l;
    tvalid = 1'b1;
    acc    = 1'b0;
    n      = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = tready_m;
      @(posedge clk);
      #1;
      n++;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout data=%0h waited=%0d cycles, required an accept", d, n);
      void'(sb.pop_back());
    end
  endtask

  // Pulse clear for one cycle with no beat offered.
  task automatic clearPulse();
    tvalid = 1'b0;
    clear  = 1'b1;
    step(1);
    clear  = 1'b0;
  endtask

  // Monitor: compare the outputs following each accepted beat, then note
  // whether the coming edge will accept. It also records tready in RUN for the
  // backpressure pattern test.
  always @(negedge clk) begin
    exp_t e;
    if (pending) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_underflow actual=accept with empty queue expected=no accept");
      end else begin
        e = sb.pop_front();
        checkOutput("sb_err_cnt", 32'(err_m), 32'(e.err));
        checkOutput("sb_pkt_cnt", 32'(pkt_m), 32'(e.pkt));
        checkOutput("sb_error", 32'(error_m), 32'(e.error));
        checkOutput("sb_halted", 32'(halt_m), 32'(e.halted));
      end
    end
    pending = !rst && tvalid && tready_m && !clear;
    if (rec_on && rec_n < 64) begin
      rec[rec_n] = tready_m;
      rec_n++;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int e_err;
    int e_pkt;
    int mism;
    int ones;
    logic [31:0] d;

    rst = 1'b1; enable = 1'b0; clear = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    tdata = '0; tkeep = 4'hF; sel = 2'd0;
    step(3);
    rst = 1'b0;
    checkOutput("rst_tready", 32'(tready_m), 0);
    checkOutput("rst_err_cnt", 32'(err_m), 0);
    checkOutput("rst_pkt_cnt", 32'(pkt_m), 0);
    checkOutput("rst_error", 32'(error_m), 0);
    checkOutput("rst_halted", 32'(halt_m), 0);

    // Clean stream 0..63 with tlast on every 16th beat.
    $display("[TB] clean stream");
    enable = 1'b1;
    step(1);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(32'(i), 4'hF, (i % 16) == 15, 0, (i + 1) / 16, 1'b0, 1'b0);
    end
    step(2);
    checkOutput("t1_pkt_cnt", 32'(pkt_m), 4);
    checkOutput("t1_err_cnt", 32'(err_m), 0);
    clearPulse();
    checkOutput("clr_err_cnt", 32'(err_m), 0);
    checkOutput("clr_pkt_cnt", 32'(pkt_m), 0);

    // Beat 5 corrupted: two errors (bad beat, then the follower vs DEAD+1).
    $display("[TB] corrupted beat");
    for (int i = 0; i < 32; i++) begin
      d     = (i == 5) ? 32'hDEAD : 32'(i);
      e_err = (i < 5) ? 0 : ((i == 5) ? 1 : 2);
      applyStimulus(d, 4'hF, (i % 16) == 15, e_err, (i + 1) / 16, i >= 5, 1'b0);
    end
    clearPulse();
    checkOutput("clr_error", 32'(error_m), 0);

    // tlast missing on beat 15 and late on beat 16; the next packet is clean.
    $display("[TB] misplaced tlast");
    for (int i = 0; i <= 32; i++) begin
      e_err = (i < 15) ? 0 : ((i == 15) ? 1 : 2);
      e_pkt = (i < 16) ? 0 : ((i < 32) ? 1 : 2);
      applyStimulus(32'(i), 4'hF, (i == 16) || (i == 32), e_err, e_pkt, i >= 15, 1'b0);
    end

    // Clear coinciding with a handshake: the beat is dropped from all checks.
    $display("[TB] clear with accept");
    tdata = 32'h1234; tlast = 1'b1; tvalid = 1'b1; clear = 1'b1;
    step(1);
    clear = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    checkOutput("clrwin_err_cnt", 32'(err_m), 0);
    checkOutput("clrwin_pkt_cnt", 32'(pkt_m), 0);
    applyStimulus(32'h0, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
    enable = 1'b0;

    // Backpressure pattern 01010101 with an always-valid source.
    $display("[TB] ready pattern");
    sel = 2'd1;
    enable = 1'b1;
    step(1);
    rec_on = 1'b1;
    for (int i = 0; i < 32; i++) begin
      applyStimulus(32'(i), 4'hF, (i % 16) == 15, 0, (i + 1) / 16, 1'b0, 1'b0);
    end
    step(3);
    rec_on = 1'b0;
    mism = 0;
    ones = 0;
    for (int j = 0; j < 64; j++) begin
      if (rec[j] !== ((j % 2) == 0)) mism++;
      if (rec[j] === 1'b1) ones++;
    end
    checkOutput("t2_samples", 32'(rec_n), 64);
    checkOutput("t2_alternation_bad", 32'(mism), 0);
    checkOutput("t2_ready_cycles", 32'(ones), 32);
    enable = 1'b0;

    // Data wrap from all-ones to zero is not an error.
    $display("[TB] data wrap");
    sel = 2'd2;
    enable = 1'b1;
    step(1);
    applyStimulus(32'hFFFF_FFFE, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0000, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
    applyStimulus(32'h0000_0001, 4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1);
    checkOutput("t5_error", 32'(error_m), 0);
    enable = 1'b0;

    // Stop-on-error instance: mid-packet disable, then halt on bad tkeep.
    $display("[TB] stop on error");
    sel = 2'd3;
    enable = 1'b1;
    step(1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'(i), 4'hF, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    enable = 1'b0;
    for (int i = 8; i < 16; i++) begin
      applyStimulus(32'(i), 4'hF, i == 15, 0, (i == 15) ? 1 : 0, 1'b0, 1'b0);
    end
    step(2);
    checkOutput("t6_idle_tready", 32'(tready_m), 0);
    checkOutput("t6_idle_halted", 32'(halt_m), 0);
    enable = 1'b1;
    step(1);
    for (int i = 16; i < 19; i++) begin
      applyStimulus(32'(i), 4'hF, 1'b0, 0, 1, 1'b0, 1'b0);
    end
    applyStimulus(32'd19, 4'h7, 1'b0, 1, 1, 1'b1, 1'b1);
    checkOutput("t6_halt_tready", 32'(tready_m), 0);
    checkOutput("t6_halted", 32'(halt_m), 1);
    tdata = 32'd20; tvalid = 1'b1;
    step(3);
    tvalid = 1'b0;
    checkOutput("t6_halt_err_cnt", 32'(err_m), 1);
    checkOutput("t6_halt_stays", 32'(halt_m), 1);
    enable = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("t6_rst_tready", 32'(tready_m), 0);
    checkOutput("t6_rst_err_cnt", 32'(err_m), 0);
    checkOutput("t6_rst_pkt_cnt", 32'(pkt_m), 0);
    checkOutput("t6_rst_error", 32'(error_m), 0);
    checkOutput("t6_rst_halted", 32'(halt_m), 0);

    step(2);
    checkOutput("sb_left_over", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
